// File: rtl/tt_proj_mux_ctrl.sv
// Project-select controller: serial address shadow, break-before-make slot switching
// (gap, forced project reset, run) and output return mux for the selected slot.
module tt_proj_mux_ctrl #(
  parameter int unsigned NUM_PROJ   = 12,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned RST_CYCLES = 8,
  parameter int unsigned IW_W       = 18,
  parameter int unsigned OW_W       = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sel_dat,
  input  logic                     sel_shift,
  input  logic                     sel_load,
  input  logic [IW_W-1:0]          chip_iw,
  input  logic [NUM_PROJ*OW_W-1:0] proj_ow,
  output logic [NUM_PROJ-1:0]      proj_ena,
  output logic [NUM_PROJ*IW_W-1:0] proj_iw,
  output logic [OW_W-1:0]          chip_ow,
  output logic [ADDR_W-1:0]        cur_sel,
  output logic                     active,
  output logic                     busy
);

  localparam int unsigned CntMax = (GAP_CYCLES > RST_CYCLES) ? GAP_CYCLES : RST_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax) + 1;
  localparam logic [ADDR_W:0] NumProjW = (ADDR_W + 1)'(NUM_PROJ);

  typedef enum logic [1:0] {StOff, StGap, StRst, StRun} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   shadow_q, shadow_d;
  logic [ADDR_W-1:0]   cur_sel_q, cur_sel_d;
  logic [NUM_PROJ-1:0] ena_q, ena_d;
  logic                rst_force_q, rst_force_d;
  logic                busy_q, busy_d;
  logic                active_q, active_d;
  logic [OW_W-1:0]     chip_ow_q, chip_ow_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_sel_d = cur_sel_q;
    shadow_d  = sel_shift ? {shadow_q[ADDR_W-2:0], sel_dat} : shadow_q;

    unique case (state_q)
      StOff, StRun: begin
        if (sel_load) begin
          cur_sel_d = shadow_q;
          cnt_d     = CntW'(GAP_CYCLES - 1);
          state_d   = StGap;
        end
      end
      StGap: begin
        if (cnt_q == '0) begin
          if ({1'b0, cur_sel_q} >= NumProjW) begin
            state_d = StOff;
          end else begin
            cnt_d   = CntW'(RST_CYCLES - 1);
            state_d = StRst;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRst: begin
        if (cnt_q == '0) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StOff;
    endcase

    // Registered outputs are decoded from the next state so they change on the entering edge.
    ena_d = '0;
    for (int k = 0; k < NUM_PROJ; k++) begin
      ena_d[k] = ((state_d == StRst) || (state_d == StRun)) &&
                 ({1'b0, cur_sel_d} == (ADDR_W + 1)'(k));
    end
    rst_force_d = (state_d == StRst);
    busy_d      = (state_d == StGap) || (state_d == StRst);
    active_d    = (state_d == StRun);

    chip_ow_d = '0;
    for (int k = 0; k < NUM_PROJ; k++) begin
      if (ena_d[k]) chip_ow_d = proj_ow[k*OW_W +: OW_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StOff;
      cnt_q       <= '0;
      shadow_q    <= '0;
      cur_sel_q   <= '0;
      ena_q       <= '0;
      rst_force_q <= 1'b0;
      busy_q      <= 1'b0;
      active_q    <= 1'b0;
      chip_ow_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      cur_sel_q   <= cur_sel_d;
      ena_q       <= ena_d;
      rst_force_q <= rst_force_d;
      busy_q      <= busy_d;
      active_q    <= active_d;
      chip_ow_q   <= chip_ow_d;
    end
  end

  // Pad inputs pass combinationally; only the enabled slot sees them, with rst_n held low in RST.
  always_comb begin
    proj_iw = '0;
    for (int k = 0; k < NUM_PROJ; k++) begin
      if (ena_q[k]) proj_iw[k*IW_W +: IW_W] = chip_iw & ~(IW_W'(rst_force_q) << 1);
    end
  end

  assign proj_ena = ena_q;
  assign chip_ow  = chip_ow_q;
  assign cur_sel  = cur_sel_q;
  assign active   = active_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_tt_proj_mux_ctrl.sv
// Directed bench for tt_proj_mux_ctrl: select sequencing, output return, ignored loads, resets.
module tb_tt_proj_mux_ctrl;

  localparam int NP = 12;
  localparam int AW = 4;
  localparam int IW = 18;
  localparam int OW = 24;
  localparam int VW = NP * IW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sel_dat = 1'b0;
  logic              sel_shift = 1'b0;
  logic              sel_load = 1'b0;
  logic [IW-1:0]     chip_iw = '0;
  logic [NP*OW-1:0]  proj_ow = '0;
  logic [NP-1:0]     proj_ena;
  logic [NP*IW-1:0]  proj_iw;
  logic [OW-1:0]     chip_ow;
  logic [AW-1:0]     cur_sel;
  logic              active;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;

  tt_proj_mux_ctrl #(
    .NUM_PROJ  (NP),
    .ADDR_W    (AW),
    .GAP_CYCLES(4),
    .RST_CYCLES(8),
    .IW_W      (IW),
    .OW_W      (OW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sel_dat  (sel_dat),
    .sel_shift(sel_shift),
    .sel_load (sel_load),
    .chip_iw  (chip_iw),
    .proj_ow  (proj_ow),
    .proj_ena (proj_ena),
    .proj_iw  (proj_iw),
    .chip_ow  (chip_ow),
    .cur_sel  (cur_sel),
    .active   (active),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_onehot();
    check("onehot", VW'($countones(proj_ena) <= 1), VW'(1));
  endtask

  function automatic logic [VW-1:0] iw_exp(input int slot, input logic [IW-1:0] v);
    logic [VW-1:0] r;
    r = '0;
    r[slot*IW +: IW] = v;
    return r;
  endfunction

  task automatic shift_addr(input logic [AW-1:0] a);
    for (int i = AW - 1; i >= 0; i--) begin
      sel_shift = 1'b1;
      sel_dat   = a[i];
      tick();
    end
    sel_shift = 1'b0;
    sel_dat   = 1'b0;
  endtask

  task automatic pulse_load();
    sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ena"}, VW'(proj_ena), '0);
    check({tag, "_iw"}, proj_iw, '0);
    check({tag, "_ow"}, VW'(chip_ow), '0);
    check({tag, "_sel"}, VW'(cur_sel), '0);
    check({tag, "_act"}, VW'(active), '0);
    check({tag, "_busy"}, VW'(busy), '0);
  endtask

  initial begin
    chip_iw = 18'h3A5F7;
    #3;
    check_all_zero("reset");
    #4;
    rst_n = 1'b1;
    tick();

    // Select slot 5: 4 gap cycles, 8 forced-reset cycles, then run.
    shift_addr(4'b0101);
    check("shift_no_load_busy", VW'(busy), '0);
    pulse_load();
    for (int i = 0; i < 4; i++) begin
      check("gap5_ena", VW'(proj_ena), '0);
      check("gap5_busy", VW'(busy), VW'(1));
      check("gap5_iw", proj_iw, '0);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      check("rst5_ena", VW'(proj_ena), VW'(12'h020));
      check("rst5_busy", VW'(busy), VW'(1));
      check("rst5_iw", proj_iw, iw_exp(5, 18'h3A5F5));
      tick();
    end
    check("run5_ena", VW'(proj_ena), VW'(12'h020));
    check("run5_busy", VW'(busy), '0);
    check("run5_act", VW'(active), VW'(1));
    check("run5_sel", VW'(cur_sel), VW'(5));
    check("run5_iw", proj_iw, iw_exp(5, 18'h3A5F7));
    chip_iw = 18'h0C3CA;
    #1;
    check("run5_iw_track", proj_iw, iw_exp(5, 18'h0C3CA));

    // Output return with one clock of latency.
    for (int k = 0; k < NP; k++) proj_ow[k*OW +: OW] = 24'hFFFFFF;
    proj_ow[5*OW +: OW] = 24'hA5C33C;
    proj_ow[2*OW +: OW] = 24'h123456;
    #1;
    check("ow_before_edge", VW'(chip_ow), '0);
    tick();
    check("ow_after_edge", VW'(chip_ow), VW'(24'hA5C33C));

    // Switch 5 -> 2.
    shift_addr(4'b0010);
    pulse_load();
    for (int i = 0; i < 4; i++) begin
      check("gap2_ena", VW'(proj_ena), '0);
      check("gap2_ow", VW'(chip_ow), '0);
      check_onehot();
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      check("rst2_ena", VW'(proj_ena), VW'(12'h004));
      check("rst2_ow", VW'(chip_ow), VW'(24'h123456));
      check_onehot();
      tick();
    end
    check("run2_act", VW'(active), VW'(1));
    check("run2_iw", proj_iw, iw_exp(2, 18'h0C3CA));

    // Out-of-range address: gap then off.
    shift_addr(4'd14);
    pulse_load();
    check("sel14", VW'(cur_sel), VW'(14));
    for (int i = 0; i < 4; i++) begin
      check("gap14_busy", VW'(busy), VW'(1));
      check("gap14_ena", VW'(proj_ena), '0);
      tick();
    end
    check("off14_ena", VW'(proj_ena), '0);
    check("off14_act", VW'(active), '0);
    check("off14_busy", VW'(busy), '0);
    check("off14_ow", VW'(chip_ow), '0);
    check("off14_iw", proj_iw, '0);
    check("off14_sel", VW'(cur_sel), VW'(14));

    // Load during RST of slot 3 is ignored.
    shift_addr(4'd3);
    pulse_load();
    repeat (4) tick();
    check("rst3_ena", VW'(proj_ena), VW'(12'h008));
    shift_addr(4'd7);
    pulse_load();
    check("ign_sel", VW'(cur_sel), VW'(3));
    check("ign_busy", VW'(busy), VW'(1));
    check("ign_ena", VW'(proj_ena), VW'(12'h008));
    repeat (2) tick();
    check("rst3_late_busy", VW'(busy), VW'(1));
    tick();
    check("run3_act", VW'(active), VW'(1));
    check("run3_busy", VW'(busy), '0);
    check("run3_sel", VW'(cur_sel), VW'(3));
    pulse_load();
    check("sel7", VW'(cur_sel), VW'(7));
    check("sel7_ena", VW'(proj_ena), '0);
    repeat (4) tick();
    check("rst7_ena", VW'(proj_ena), VW'(12'h080));
    repeat (8) tick();
    check("run7_act", VW'(active), VW'(1));

    // Async reset mid-gap.
    shift_addr(4'd5);
    pulse_load();
    tick();
    rst_n = 1'b0;
    #1;
    check_all_zero("rstgap");
    rst_n = 1'b1;
    tick();
    check_all_zero("off_after_rst");
    pulse_load();
    check("shadow0_sel", VW'(cur_sel), '0);
    check("shadow0_busy", VW'(busy), VW'(1));
    repeat (4) tick();
    check("rst0_ena", VW'(proj_ena), VW'(12'h001));
    repeat (8) tick();
    check("run0_act", VW'(active), VW'(1));
    check("run0_ow", VW'(chip_ow), VW'(24'hFFFFFF));

    // Async reset mid-run.
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rstrun");
    rst_n = 1'b1;
    tick();
    check_all_zero("off_after_rst2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tt_proj_mux_ctrl.md
Name: tt_proj_mux_ctrl

Overview:
- Project-select controller that sits directly upstream of every per-slot project wrapper.
- Receives the chip-level pad bundle (uio_in, ui_in, project rst_n, project clk: 18 bits) and a serial select interface.
- Drives per-slot ena and per-slot iw buses, and returns the selected slot's 24-bit ow bundle (uio_oe, uio_out, uo_out) to the pads.
- Switching is break-before-make: a gap, then a forced project reset, then normal operation.

Parameters:
- NUM_PROJ, 12, number of project slots.
- ADDR_W, 4, width of the select address.
- GAP_CYCLES, 4, clk cycles with all slots disabled between deselect and select; must be ≥1.
- RST_CYCLES, 8, clk cycles the new slot's rst_n bit is forced low after enable; must be ≥1.
- IW_W, 18, width of the per-slot input bundle.
- OW_W, 24, width of the per-slot output bundle.

Ports:
- clk  in  1  controller clock
- rst_n  in  1  async active-low reset
- sel_dat  in  1  serial address bit
- sel_shift  in  1  one-cycle strobe; shifts sel_dat into the shadow register
- sel_load  in  1  one-cycle strobe; commits the shadow address
- chip_iw  in  IW_W  pad bundle {uio_in[7:0], ui_in[7:0], rst_n, clk}; bit0 = project clk, bit1 = project rst_n
- proj_ow  in  NUM_PROJ*OW_W  concatenated slot outputs; slot k at [k*OW_W +: OW_W]
- proj_ena  out  NUM_PROJ  one-hot-or-zero slot enable
- proj_iw  out  NUM_PROJ*IW_W  per-slot input bundles
- chip_ow  out  OW_W  selected slot output to pads
- cur_sel  out  ADDR_W  committed address
- active  out  1  a valid slot is in RUN state
- busy  out  1  controller in GAP or RST state

Behaviour:
- Reset (async, rst_n low):
  - shadow = 0, cur_sel = 0, state OFF.
  - proj_ena = 0, proj_iw = 0, chip_ow = 0, active = 0, busy = 0.
- Shadow register:
  - Each clk with sel_shift=1: shadow <= {shadow[ADDR_W-2:0], sel_dat} (MSB first).
  - Shifting is allowed in every state.
- Load:
  - sel_load=1 in OFF or RUN: cur_sel <= shadow (pre-shift value if sel_shift is simultaneous), counter <= GAP_CYCLES-1, state -> GAP.
  - sel_load in GAP or RST is ignored; cur_sel is unchanged.
  - Loading the same address as the current one still performs the full GAP/RST sequence.
- FSM states:
  - OFF: proj_ena = 0; all proj_iw slots = 0; chip_ow = 0.
  - GAP: proj_ena = 0; proj_iw all 0; busy = 1. Counter decrements each cycle. At 0: if cur_sel ≥ NUM_PROJ go to OFF, else load counter RST_CYCLES-1 and go to RST.
  - RST: proj_ena[cur_sel] = 1. proj_iw[cur_sel] = chip_iw with bit1 forced 0; clk bit passes. busy = 1. At counter 0 go to RUN.
  - RUN: proj_ena[cur_sel] = 1; proj_iw[cur_sel] = chip_iw unmodified; active = 1.
- Unselected slots always receive all-zero iw and ena = 0.
- proj_ena, busy and active are registered from state and cur_sel; they change on the clk edge that enters the state.
- proj_iw is combinational from chip_iw, gated by the registered slot-enable and RST flag; no added latency on the pad path.
- chip_ow is registered: chip_ow <= proj_ow[cur_sel] in RST or RUN, else 0. Latency is 1 clk from proj_ow to chip_ow.
- proj_ena has at most one bit set in any cycle.
- Switching from slot A to slot B always has ≥ GAP_CYCLES cycles with proj_ena == 0 between them.
- Async reset mid-sequence: immediately OFF with all outputs zero; no partial enable survives.

Test Plan:
- Reset, then shift 4'b0101 (four sel_shift pulses) and pulse sel_load → busy=1 for 4+8 cycles; proj_ena=12'h000 for 4 cycles, then 12'h020. Slot-5 iw bit1=0 for 8 cycles, then tracks chip_iw; active=1; cur_sel=5.
- In RUN slot 5, drive proj_ow slot 5 = 24'hA5C33C, other slots 24'hFFFFFF → chip_ow=24'hA5C33C exactly 1 clk later; all non-5 proj_iw = 0.
- Switch 5→2 → proj_ena goes 12'h020 → 12'h000 (4 cycles) → 12'h004; never two bits set simultaneously; chip_ow=0 during GAP.
- Load address 4'd14 (≥ NUM_PROJ) → GAP 4 cycles then OFF: proj_ena=0, active=0, chip_ow=0, cur_sel=14.
- sel_load pulsed during the RST phase of slot 3 with shadow=7 → ignored: cur_sel stays 3, RUN is reached on schedule. A later load in RUN selects 7.
- Assert rst_n mid-GAP and mid-RUN → all outputs 0 asynchronously. After release, state OFF and shadow=0.
